alu_cmd_responder: RTL and testbench

Request/response front end for alu_32. Accepts ALU commands (a, b, op, tag) on a valid/ready channel and runs them through a 2-stage pipeline around one alu_32 instance. Results go into a response FIFO with its own valid/ready channel. Also keeps status counters. Test benches and future processor datapath blocks use it in place of driving alu_32 ports directly.

---
 rtl/alu_pkg.sv | 27 ++
 rtl/alu_cmd_responder_if.sv | 34 +++
 rtl/alu_32.sv | 46 ++++
 rtl/alu_rsp_fifo.sv | 55 +++++
 rtl/alu_cmd_responder.sv | 124 ++++++++++++
 tb/tb_alu_cmd_responder.sv | 255 +++++++++++++++++++++++++
 6 files changed

// File: rtl/alu_pkg.sv
// Shared ALU definitions: op codes and the response record that travels
// from the pipeline into the response FIFO.
package alu_pkg;

  localparam int DATA_W = 32;

  localparam logic [3:0] OP_ADD = 4'd0;
  localparam logic [3:0] OP_SUB = 4'd1;
  localparam logic [3:0] OP_AND = 4'd2;
  localparam logic [3:0] OP_OR  = 4'd3;
  localparam logic [3:0] OP_XOR = 4'd4;
  localparam logic [3:0] OP_NOR = 4'd5;
  localparam logic [3:0] OP_SLT = 4'd6;
  localparam logic [3:0] OP_SLL = 4'd7;
  localparam logic [3:0] OP_SRL = 4'd8;

  // Result + flags of one response. The tag travels beside it because its
  // width is a per-instance parameter.
  typedef struct packed {
    logic [DATA_W-1:0] result;
    logic              carry;
    logic              overflow;
    logic              zero;
    logic              err;
  } alu_res_t;

endpackage

// File: rtl/alu_cmd_responder_if.sv
// Command and response channels of the ALU responder.
interface alu_cmd_responder_if #(
  parameter int TAG_W = 4
);
  logic             cmd_valid;
  logic             cmd_ready;
  logic [31:0]      cmd_a;
  logic [31:0]      cmd_b;
  logic [3:0]       cmd_op;
  logic [TAG_W-1:0] cmd_tag;

  logic             rsp_valid;
  logic             rsp_ready;
  logic [31:0]      rsp_result;
  logic             rsp_carry;
  logic             rsp_overflow;
  logic             rsp_zero;
  logic             rsp_err;
  logic [TAG_W-1:0] rsp_tag;

  // Requester side: issues commands, consumes responses.
  modport master (
    output cmd_valid, cmd_a, cmd_b, cmd_op, cmd_tag, rsp_ready,
    input  cmd_ready, rsp_valid, rsp_result, rsp_carry, rsp_overflow,
           rsp_zero, rsp_err, rsp_tag
  );

  // Responder side.
  modport slave (
    input  cmd_valid, cmd_a, cmd_b, cmd_op, cmd_tag, rsp_ready,
    output cmd_ready, rsp_valid, rsp_result, rsp_carry, rsp_overflow,
           rsp_zero, rsp_err, rsp_tag
  );
endinterface

// File: rtl/alu_32.sv
// 32-bit combinational ALU. Unknown op codes produce a zero result.
module alu_32
  import alu_pkg::*;
(
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic [3:0]  op,
  output logic [31:0] result,
  output logic        carryout,
  output logic        overflow,
  output logic        zero
);
  logic [32:0] w_sum;

  // Operation select; carry/overflow only meaningful for add and sub.
  always_comb begin
    w_sum    = '0;
    result   = '0;
    carryout = 1'b0;
    overflow = 1'b0;
    case (op)
      OP_ADD: begin
        w_sum    = {1'b0, a} + {1'b0, b};
        result   = w_sum[31:0];
        carryout = w_sum[32];
        overflow = (a[31] == b[31]) && (w_sum[31] != a[31]);
      end
      OP_SUB: begin
        w_sum    = {1'b0, a} + {1'b0, ~b} + 33'd1;
        result   = w_sum[31:0];
        carryout = w_sum[32];
        overflow = (a[31] != b[31]) && (w_sum[31] != a[31]);
      end
      OP_AND:  result = a & b;
      OP_OR:   result = a | b;
      OP_XOR:  result = a ^ b;
      OP_NOR:  result = ~(a | b);
      OP_SLT:  result = {31'd0, ($signed(a) < $signed(b))};
      OP_SLL:  result = a << b[4:0];
      OP_SRL:  result = a >> b[4:0];
      default: result = '0;
    endcase
  end

  assign zero = (result == 32'd0);
endmodule

// File: rtl/alu_rsp_fifo.sv
// Synchronous response FIFO with show-ahead head and occupancy count.
module alu_rsp_fifo
  import alu_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int TAG_W = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     i_push,
  input  alu_res_t                 i_res,
  input  logic [TAG_W-1:0]         i_tag,
  input  logic                     i_pop,
  output alu_res_t                 o_res,
  output logic [TAG_W-1:0]         o_tag,
  output logic [$clog2(DEPTH):0]   o_count,
  output logic                     o_empty
);
  localparam int AW = $clog2(DEPTH);

  alu_res_t         r_res [DEPTH];
  logic [TAG_W-1:0] r_tag [DEPTH];
  logic [AW-1:0]    r_wptr, r_rptr;
  logic [AW:0]      r_count;

  // Storage needs no reset; the top masks the head while empty.
  always_ff @(posedge clk) begin
    if (i_push) begin
      r_res[r_wptr] <= i_res;
      r_tag[r_wptr] <= i_tag;
    end
  end

  // Pointers wrap naturally (DEPTH is a power of two); count tracks push/pop.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (i_push) r_wptr <= r_wptr + 1'b1;
      if (i_pop)  r_rptr <= r_rptr + 1'b1;
      case ({i_push, i_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  assign o_res   = r_res[r_rptr];
  assign o_tag   = r_tag[r_rptr];
  assign o_count = r_count;
  assign o_empty = (r_count == '0);
endmodule

// File: rtl/alu_cmd_responder.sv
// Valid/ready front end for alu_32: one command register stage, the ALU,
// then a response FIFO. Credits stop intake before the FIFO can overflow.
module alu_cmd_responder
  import alu_pkg::*;
#(
  parameter int DEPTH  = 4,
  parameter int TAG_W  = 4,
  parameter int MAX_OP = 8
) (
  input  logic               clk,
  input  logic               rst,
  alu_cmd_responder_if.slave bus,
  output logic               busy,
  output logic [15:0]        cmd_cnt,
  output logic [15:0]        ovf_cnt
);
  localparam int         CW       = $clog2(DEPTH) + 1;
  localparam logic [3:0] MAX_OP_L = 4'(MAX_OP);

  logic             r_s1_valid;
  logic [31:0]      r_a, r_b;
  logic [3:0]       r_op;
  logic [TAG_W-1:0] r_tag;
  logic [15:0]      r_cmd_cnt, r_ovf_cnt;

  logic             w_accept, w_pop, w_empty;
  logic [CW-1:0]    w_count;
  logic [CW:0]      w_used;
  logic [31:0]      w_alu_res;
  logic             w_alu_c, w_alu_v, w_alu_z;
  alu_res_t         w_wr, w_head, w_out;
  logic [TAG_W-1:0] w_head_tag;

  // Credit: an entry in S1 already owns a FIFO slot. Only state and reset feed it.
  assign w_used        = {1'b0, w_count} + {{CW{1'b0}}, r_s1_valid};
  assign bus.cmd_ready = !rst && (w_used < (CW+1)'(DEPTH));
  assign w_accept      = bus.cmd_valid && bus.cmd_ready;
  assign w_pop         = bus.rsp_valid && bus.rsp_ready;

  // Stage 1: capture the command; valid lasts one cycle per accept.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_s1_valid <= 1'b0;
      r_a        <= '0;
      r_b        <= '0;
      r_op       <= '0;
      r_tag      <= '0;
    end else begin
      r_s1_valid <= w_accept;
      if (w_accept) begin
        r_a   <= bus.cmd_a;
        r_b   <= bus.cmd_b;
        r_op  <= bus.cmd_op;
        r_tag <= bus.cmd_tag;
      end
    end
  end

  alu_32 u_alu (
    .a        (r_a),
    .b        (r_b),
    .op       (r_op),
    .result   (w_alu_res),
    .carryout (w_alu_c),
    .overflow (w_alu_v),
    .zero     (w_alu_z)
  );

  // Stage 2 record: illegal ops report err with everything else cleared.
  always_comb begin
    w_wr = '0;
    if (r_op > MAX_OP_L) begin
      w_wr.err = 1'b1;
    end else begin
      w_wr.result   = w_alu_res;
      w_wr.carry    = w_alu_c;
      w_wr.overflow = w_alu_v;
      w_wr.zero     = w_alu_z;
    end
  end

  alu_rsp_fifo #(.DEPTH(DEPTH), .TAG_W(TAG_W)) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .i_push  (r_s1_valid),
    .i_res   (w_wr),
    .i_tag   (r_tag),
    .i_pop   (w_pop),
    .o_res   (w_head),
    .o_tag   (w_head_tag),
    .o_count (w_count),
    .o_empty (w_empty)
  );

  // Status counters: command count wraps, overflow count saturates.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_cmd_cnt <= '0;
      r_ovf_cnt <= '0;
    end else begin
      if (w_accept) r_cmd_cnt <= r_cmd_cnt + 16'd1;
      if (r_s1_valid && w_wr.overflow && (r_ovf_cnt != 16'hFFFF))
        r_ovf_cnt <= r_ovf_cnt + 16'd1;
    end
  end

  // Head fields read as zero while the FIFO holds nothing.
  always_comb begin
    w_out = '0;
    if (!w_empty) w_out = w_head;
  end

  assign bus.rsp_valid    = !w_empty;
  assign bus.rsp_result   = w_out.result;
  assign bus.rsp_carry    = w_out.carry;
  assign bus.rsp_overflow = w_out.overflow;
  assign bus.rsp_zero     = w_out.zero;
  assign bus.rsp_err      = w_out.err;
  assign bus.rsp_tag      = w_empty ? '0 : w_head_tag;

  assign busy    = r_s1_valid || !w_empty;
  assign cmd_cnt = r_cmd_cnt;
  assign ovf_cnt = r_ovf_cnt;
endmodule

// File: tb/tb_alu_cmd_responder.sv
// Directed bench for alu_cmd_responder with a response scoreboard.
module tb_alu_cmd_responder;
  logic        clk = 1'b0;
  logic        rst;
  logic        busy;
  logic [15:0] cmd_cnt, ovf_cnt;

  int n_cmp = 0;
  int n_err = 0;
  int n_acc = 0;
  int n_ovf = 0;
  logic [39:0] scb[$];

  alu_cmd_responder_if #(.TAG_W(4)) bus ();

  alu_cmd_responder #(.DEPTH(4), .TAG_W(4), .MAX_OP(8)) dut (
    .clk     (clk),
    .rst     (rst),
    .bus     (bus),
    .busy    (busy),
    .cmd_cnt (cmd_cnt),
    .ovf_cnt (ovf_cnt)
  );

  always #5 clk = ~clk;

  // {tag, result, carry, overflow, zero, err}
  function automatic logic [39:0] model(input logic [31:0] a, input logic [31:0] b,
                                        input logic [3:0] op, input logic [3:0] tag);
    logic [31:0] r;
    logic        c, v;
    longint      sa, sbv, s;
    r = '0; c = 1'b0; v = 1'b0; s = 0;
    sa  = longint'($signed(a));
    sbv = longint'($signed(b));
    case (op)
      4'd0: begin
        r = a + b;
        c = (({32'd0, a} + {32'd0, b}) > 64'h0000_0000_FFFF_FFFF);
        s = sa + sbv;
        v = (s > 64'sd2147483647) || (s < -64'sd2147483648);
      end
      4'd1: begin
        r = a - b;
        c = (a >= b);
        s = sa - sbv;
        v = (s > 64'sd2147483647) || (s < -64'sd2147483648);
      end
      4'd2: r = a & b;
      4'd3: r = a | b;
      4'd4: r = a ^ b;
      4'd5: r = ~(a | b);
      4'd6: r = (sa < sbv) ? 32'd1 : 32'd0;
      4'd7: r = a << b[4:0];
      4'd8: r = a >> b[4:0];
      default: return {tag, 32'd0, 4'b0001};
    endcase
    return {tag, r, c, v, (r == 32'd0), 1'b0};
  endfunction

  function automatic logic [39:0] obs_rsp();
    return {bus.rsp_tag, bus.rsp_result, bus.rsp_carry, bus.rsp_overflow,
            bus.rsp_zero, bus.rsp_err};
  endfunction

  task automatic chk(input string name, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", name, obs, exp);
    end
  endtask

  // One clock: score pops and accepts at the negedge, return #1 after posedge.
  task automatic cycle();
    logic [39:0] e;
    @(negedge clk);
    if (bus.rsp_valid && bus.rsp_ready) begin
      if (scb.size() == 0) begin
        n_cmp++;
        n_err++;
        $error("FAIL unexpected_rsp observed=%h expected=none", obs_rsp());
      end else begin
        e = scb.pop_front();
        chk("rsp", 64'(obs_rsp()), 64'(e));
      end
    end
    if (bus.cmd_valid && bus.cmd_ready) begin
      e = model(bus.cmd_a, bus.cmd_b, bus.cmd_op, bus.cmd_tag);
      scb.push_back(e);
      n_acc++;
      if (e[2]) n_ovf++;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [31:0] a, input logic [31:0] b,
                       input logic [3:0] op, input logic [3:0] tag);
    bus.cmd_a = a; bus.cmd_b = b; bus.cmd_op = op; bus.cmd_tag = tag;
  endtask

  // Single command with an idle pipe: checks the two-edge latency.
  task automatic send_one(input logic [31:0] a, input logic [31:0] b,
                          input logic [3:0] op, input logic [3:0] tag,
                          output logic [39:0] seen);
    drive(a, b, op, tag);
    bus.cmd_valid = 1'b1;
    cycle();
    bus.cmd_valid = 1'b0;
    chk("lat_edge1_valid", 64'(bus.rsp_valid), 64'd0);
    cycle();
    chk("lat_edge2_valid", 64'(bus.rsp_valid), 64'd1);
    seen = obs_rsp();
    bus.rsp_ready = 1'b1;
    cycle();
    bus.rsp_ready = 1'b0;
  endtask

  task automatic drain();
    int k;
    k = 0;
    bus.rsp_ready = 1'b1;
    while ((scb.size() != 0 || busy) && k < 50) begin
      cycle();
      k++;
    end
    chk("drain_left", 64'(scb.size()), 64'd0);
    chk("drain_busy", 64'(busy), 64'd0);
    chk("cmd_cnt", 64'(cmd_cnt), 64'(n_acc));
    chk("ovf_cnt", 64'(ovf_cnt), 64'(n_ovf));
  endtask

  initial begin
    logic [39:0] seen;
    logic [3:0]  t;
    int          acc0, k;

    rst = 1'b1;
    bus.cmd_valid = 1'b0;
    bus.rsp_ready = 1'b0;
    drive('0, '0, '0, '0);
    repeat (2) @(posedge clk);
    #1;
    chk("rst_cmd_ready", 64'(bus.cmd_ready), 64'd0);
    chk("rst_rsp_valid", 64'(bus.rsp_valid), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_cmd_cnt", 64'(cmd_cnt), 64'd0);
    chk("rst_ovf_cnt", 64'(ovf_cnt), 64'd0);
    chk("rst_rsp_data", 64'(obs_rsp()), 64'd0);
    rst = 1'b0;
    #1;
    chk("post_rst_ready", 64'(bus.cmd_ready), 64'd1);

    // Directed ALU cases
    send_one(32'h7FFF_FFF1, 32'h0014_0656, 4'd0, 4'd3, seen);
    chk("add_result", 64'(seen[35:4]), 64'h8014_0647);
    chk("add_flags", 64'(seen[3:0]), 64'b0100);
    chk("add_tag", 64'(seen[39:36]), 64'd3);
    chk("add_ovf_cnt", 64'(ovf_cnt), 64'd1);

    send_one(32'h0014_5BC4, 32'h8000_0011, 4'd1, 4'd5, seen);
    chk("sub_result", 64'(seen[35:4]), 64'h8014_5BB3);
    chk("sub_flags", 64'(seen[3:0]), 64'b0100);
    chk("sub_ovf_cnt", 64'(ovf_cnt), 64'd2);

    send_one(32'd5, 32'd5, 4'd1, 4'd6, seen);
    chk("zero_result", 64'(seen[35:4]), 64'd0);
    chk("zero_flags", 64'(seen[3:0]), 64'b1010);

    send_one(32'd1234, 32'd5678, 4'd15, 4'd9, seen);
    chk("illegal_rsp", 64'(seen), 64'({4'd9, 32'd0, 4'b0001}));

    send_one(32'hFFFF_0000, 32'd1, 4'd9, 4'd10, seen);
    chk("op9_err", 64'(seen), 64'({4'd10, 32'd0, 4'b0001}));

    send_one(32'h8000_0000, 32'd4, 4'd8, 4'd11, seen);
    chk("op8_srl", 64'(seen), 64'({4'd11, 32'h0800_0000, 4'b0000}));
    drain();

    // Backpressure: payload only advances on accept
    bus.rsp_ready = 1'b0;
    t = 4'd0;
    acc0 = n_acc;
    drive(32'h0101_0101 * t + 32'd7, 32'h10 - 32'(t), t, t);
    bus.cmd_valid = 1'b1;
    for (int i = 0; i < 8; i++) begin
      k = n_acc;
      cycle();
      if (n_acc != k) begin
        t = t + 4'd1;
        drive(32'h0101_0101 * 32'(t) + 32'd7, 32'h10 - 32'(t), t, t);
      end
    end
    chk("bp_accepts", 64'(n_acc - acc0), 64'd4);
    chk("bp_cmd_ready", 64'(bus.cmd_ready), 64'd0);
    chk("bp_busy", 64'(busy), 64'd1);
    bus.rsp_ready = 1'b1;
    k = 0;
    while (t != 4'd8 && k < 40) begin
      acc0 = n_acc;
      cycle();
      if (n_acc != acc0) begin
        t = t + 4'd1;
        drive(32'h0101_0101 * 32'(t) + 32'd7, 32'h10 - 32'(t), t, t);
      end
      k++;
    end
    bus.cmd_valid = 1'b0;
    chk("bp_all_sent", 64'(t), 64'd8);
    drain();

    // Reset with three commands in flight
    bus.rsp_ready = 1'b0;
    bus.cmd_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      drive(32'h7FFF_FFF0 + 32'(i), 32'h10, 4'd0, 4'(i + 12));
      cycle();
    end
    bus.cmd_valid = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    chk("mid_rst_ready", 64'(bus.cmd_ready), 64'd0);
    @(posedge clk);
    #1;
    scb.delete();
    n_acc = 0;
    n_ovf = 0;
    rst = 1'b0;
    #1;
    chk("mid_rst_rsp_valid", 64'(bus.rsp_valid), 64'd0);
    chk("mid_rst_busy", 64'(busy), 64'd0);
    chk("mid_rst_cnts", 64'({cmd_cnt, ovf_cnt}), 64'd0);
    chk("mid_rst_ready_after", 64'(bus.cmd_ready), 64'd1);
    bus.rsp_ready = 1'b1;
    repeat (4) cycle();
    chk("mid_rst_no_stale", 64'(bus.rsp_valid), 64'd0);

    // Streaming: one accept per cycle with consumer always ready
    for (int i = 0; i < 16; i++) begin
      if (i == 3) drive(32'h7FFF_FFFF, 32'd1, 4'd0, 4'(i));
      else drive($urandom, $urandom, 4'($urandom_range(0, 15)), 4'(i));
      bus.cmd_valid = 1'b1;
      chk("stream_ready", 64'(bus.cmd_ready), 64'd1);
      cycle();
    end
    bus.cmd_valid = 1'b0;
    chk("stream_accepts", 64'(n_acc), 64'd16);
    chk("stream_cmd_cnt", 64'(cmd_cnt), 64'd16);
    drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
